// File: rtl/mac_iter_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_iter_unit_if
// Description : CPU internal-bus bundle between the core and the MAC unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_iter_unit_if #(
    parameter int W = 32
);
    logic [W-1:0] CBUS_DI;
    logic [W-1:0] CBUS_DO;
    logic         CBUS_REQ;
    logic         CBUS_BUSY;
    logic [1:0]   MAC_SEL;
    logic [3:0]   MAC_OP;
    logic         MAC_WE;
    logic         SAT;

    modport master (
        output CBUS_DI, CBUS_REQ, MAC_SEL, MAC_OP, MAC_WE, SAT,
        input  CBUS_DO, CBUS_BUSY
    );

    modport slave (
        input  CBUS_DI, CBUS_REQ, MAC_SEL, MAC_OP, MAC_WE, SAT,
        output CBUS_DO, CBUS_BUSY
    );
endinterface
`default_nettype wire

// File: rtl/mac_iter_unit.sv
`default_nettype none
// ============================================================================
// Module      : mac_iter_unit
// Description : SH MACH/MACL unit with iterative shift-add multiplier.
//               Optional MAC saturation built when MAC_ITER_SAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_iter_unit #(
    parameter int W  = 32,
    parameter int RB = 8
) (
    input  wire            CLK,
    input  wire            RST,
    input  wire            CE_R,
    mac_iter_unit_if.slave bus
);
    localparam int c_n  = W / RB;
    localparam int c_cw = (c_n > 1) ? $clog2(c_n) : 1;
    localparam int c_h  = W / 2;

    localparam logic [3:0] c_op_lds   = 4'b0000;
    localparam logic [3:0] c_op_mull  = 4'b0001;
    localparam logic [3:0] c_op_dmulu = 4'b0010;
    localparam logic [3:0] c_op_dmuls = 4'b0011;
    localparam logic [3:0] c_op_muluw = 4'b0110;
    localparam logic [3:0] c_op_mulsw = 4'b0111;
    localparam logic [3:0] c_op_macl  = 4'b1001;
    localparam logic [3:0] c_op_macw  = 4'b1011;
    localparam logic [3:0] c_op_clr   = 4'b1111;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [c_cw-1:0] cnt_q, cnt_d;
    logic [3:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic [W-1:0]    ma_q, ma_d, mb_q, mb_d;
    logic [W-1:0]    mach_q, mach_d, macl_q, macl_d;
    logic [2*W-1:0]  part_q, part_d;

    logic            sel_any, accept, is_mul, is_word;
    logic [W-1:0]    lo_ext, hi_ext, lo_sext;
    logic [W-1:0]    ma_in, mb_in, ma_abs, mb_abs;
    logic [2*W-1:0]  pp, prod, acc_sum;
    int              shamt;

`ifdef MAC_ITER_SAT_EN
    localparam logic signed [2*W:0] c_l_max = {{(c_h + 2){1'b0}}, {(3*W/2 - 1){1'b1}}};
    localparam logic signed [2*W:0] c_l_min = ~c_l_max;
    localparam logic signed [2*W:0] c_w_max = {{(W + 2){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [2*W:0] c_w_min = ~c_w_max;
    logic                 sat_q, sat_d;
    logic signed [2*W:0]  sum_l, sum_w;
`endif

    assign bus.CBUS_DO   = bus.MAC_SEL[1] ? mach_q : macl_q;
    assign bus.CBUS_BUSY = (state_q != S_IDLE) & (bus.CBUS_REQ | (bus.MAC_WE & sel_any));

    always_comb begin
        sel_any = |bus.MAC_SEL;
        accept  = bus.MAC_WE & sel_any & CE_R & (state_q == S_IDLE);
        is_word = (bus.MAC_OP == c_op_muluw) || (bus.MAC_OP == c_op_mulsw);
        is_mul  = (bus.MAC_OP == c_op_mull)  || (bus.MAC_OP == c_op_dmulu) ||
                  (bus.MAC_OP == c_op_dmuls) || is_word ||
                  (bus.MAC_OP == c_op_macl)  || (bus.MAC_OP == c_op_macw);

        lo_sext = {{c_h{bus.CBUS_DI[c_h-1]}}, bus.CBUS_DI[c_h-1:0]};
        lo_ext  = bus.MAC_OP[0] ? lo_sext : {{c_h{1'b0}}, bus.CBUS_DI[c_h-1:0]};
        hi_ext  = bus.MAC_OP[0] ? {{c_h{bus.CBUS_DI[W-1]}}, bus.CBUS_DI[W-1:c_h]}
                                : {{c_h{1'b0}}, bus.CBUS_DI[W-1:c_h]};

        // Word multiplies take both operands from one DI word; MAC.W takes
        // the low half of DI at each step; long ops take the whole word.
        ma_in = ma_q;
        mb_in = mb_q;
        if (is_word) begin
            if (sel_any)        ma_in = lo_ext;
            if (bus.MAC_SEL[1]) mb_in = hi_ext;
        end else if (bus.MAC_OP == c_op_macw) begin
            if (bus.MAC_SEL[0]) ma_in = lo_sext;
            if (bus.MAC_SEL[1]) mb_in = lo_sext;
        end else begin
            if (bus.MAC_SEL[0]) ma_in = bus.CBUS_DI;
            if (bus.MAC_SEL[1]) mb_in = bus.CBUS_DI;
        end
        ma_abs = (bus.MAC_OP[0] & ma_in[W-1]) ? (W'(0) - ma_in) : ma_in;
        mb_abs = (bus.MAC_OP[0] & mb_in[W-1]) ? (W'(0) - mb_in) : mb_in;

        shamt   = (c_n - 1 - int'(cnt_q)) * RB;
        pp      = {{W{1'b0}}, mb_q} * {{(2*W-RB){1'b0}}, ma_q[RB-1:0]};
        prod    = neg_q ? ((2*W)'(0) - part_q) : part_q;
        acc_sum = {mach_q, macl_q} + prod;
`ifdef MAC_ITER_SAT_EN
        sum_l = $signed({mach_q[W-1], mach_q, macl_q}) + $signed({prod[2*W-1], prod});
        sum_w = $signed({{(W+1){macl_q[W-1]}}, macl_q}) + $signed({prod[2*W-1], prod});
        sat_d = sat_q;
`endif

        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        mach_d  = mach_q;
        macl_d  = macl_q;
        part_d  = part_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bus.MAC_OP == c_op_lds) begin
                        if (bus.MAC_SEL[0]) macl_d = bus.CBUS_DI;
                        if (bus.MAC_SEL[1]) mach_d = bus.CBUS_DI;
                    end else if (bus.MAC_OP == c_op_clr) begin
                        mach_d = '0;
                        macl_d = '0;
                    end else if (is_mul && bus.MAC_SEL[1]) begin
                        ma_d    = ma_abs;
                        mb_d    = mb_abs;
                        op_d    = bus.MAC_OP;
                        neg_d   = bus.MAC_OP[0] & (ma_in[W-1] ^ mb_in[W-1]);
                        cnt_d   = c_cw'(c_n - 1);
                        part_d  = '0;
                        state_d = S_RUN;
`ifdef MAC_ITER_SAT_EN
                        sat_d   = bus.SAT;
`endif
                    end else if (is_mul) begin
                        ma_d = ma_in;
                        mb_d = mb_in;
                    end
                end
            end
            S_RUN: begin
                if (CE_R) begin
                    part_d = part_q + (pp << shamt);
                    ma_d   = ma_q >> RB;
                    if (cnt_q == '0) state_d = S_DONE;
                    else             cnt_d   = cnt_q - c_cw'(1);
                end
            end
            S_DONE: begin
                if (CE_R) begin
                    state_d = S_IDLE;
                    case (op_q)
                        c_op_mull, c_op_muluw, c_op_mulsw: macl_d = prod[W-1:0];
                        c_op_dmulu, c_op_dmuls:            {mach_d, macl_d} = prod;
                        c_op_macl, c_op_macw: begin
                            {mach_d, macl_d} = acc_sum;
`ifdef MAC_ITER_SAT_EN
                            if (sat_q && (op_q == c_op_macl)) begin
                                if (sum_l > c_l_max)      {mach_d, macl_d} = c_l_max[2*W-1:0];
                                else if (sum_l < c_l_min) {mach_d, macl_d} = c_l_min[2*W-1:0];
                            end else if (sat_q) begin
                                mach_d = mach_q;
                                if (sum_w > c_w_max)      macl_d = c_w_max[W-1:0];
                                else if (sum_w < c_w_min) macl_d = c_w_min[W-1:0];
                                else                      macl_d = sum_w[W-1:0];
                            end
`endif
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            ma_q    <= '0;
            mb_q    <= '0;
            mach_q  <= '0;
            macl_q  <= '0;
            part_q  <= '0;
`ifdef MAC_ITER_SAT_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            mach_q  <= mach_d;
            macl_q  <= macl_d;
            part_q  <= part_d;
`ifdef MAC_ITER_SAT_EN
            sat_q   <= sat_d;
`endif
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mac_iter_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_iter_unit
// Description : Directed self-checking bench for mac_iter_unit (W=32, RB=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_iter_unit;
    localparam logic [3:0] c_lds = 4'b0000, c_mull = 4'b0001, c_dmulu = 4'b0010,
                           c_dmuls = 4'b0011, c_muluw = 4'b0110, c_mulsw = 4'b0111,
                           c_macl = 4'b1001, c_macw = 4'b1011, c_clr = 4'b1111;

    logic r_clk = 1'b0;
    logic r_rst = 1'b1;
    logic r_ce  = 1'b1;
    int   r_checks = 0;
    int   r_fails  = 0;

    mac_iter_unit_if #(.W(32)) bus ();

    mac_iter_unit #(.W(32), .RB(8)) u_dut (
        .CLK  (r_clk),
        .RST  (r_rst),
        .CE_R (r_ce),
        .bus  (bus)
    );

    always #5 r_clk = ~r_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        r_checks++;
        if (act !== exp) begin
            r_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic cmd(input logic [3:0] op, input logic [1:0] sel, input logic [31:0] di,
                       input logic sat);
        bus.MAC_OP = op; bus.MAC_SEL = sel; bus.CBUS_DI = di; bus.SAT = sat; bus.MAC_WE = 1'b1;
        tick();
        bus.MAC_WE = 1'b0; bus.MAC_SEL = 2'b00;
    endtask

    task automatic rd(input logic hi, output logic [31:0] v);
        logic [1:0] s;
        s = bus.MAC_SEL;
        bus.MAC_SEL = {hi, 1'b0};
        #1;
        v = bus.CBUS_DO;
        bus.MAC_SEL = s;
    endtask

    task automatic check_mac(input string tag, input logic [31:0] exp_h, input logic [31:0] exp_l);
        logic [31:0] h, l;
        rd(1'b1, h);
        rd(1'b0, l);
        check(tag, {h, l}, {exp_h, exp_l});
    endtask

    task automatic lds(input logic [31:0] h, input logic [31:0] l);
        cmd(c_lds, 2'b10, h, 1'b0);
        cmd(c_lds, 2'b01, l, 1'b0);
    endtask

    task automatic busy_count(input int gap_lo, input int gap_hi, output int n);
        bit done;
        n = 0;
        done = 1'b0;
        bus.CBUS_REQ = 1'b1; bus.MAC_SEL = 2'b10;
        for (int i = 0; i < 30 && !done; i++) begin
            r_ce = (i >= gap_lo && i <= gap_hi) ? 1'b0 : 1'b1;
            #1;
            if (bus.CBUS_BUSY) begin
                n++;
                tick();
            end else begin
                done = 1'b1;
            end
        end
        r_ce = 1'b1;
    endtask

    initial begin
        logic [31:0] v;
        int          n;
        bus.CBUS_DI = '0; bus.CBUS_REQ = 1'b0; bus.MAC_SEL = 2'b00;
        bus.MAC_OP = 4'b0000; bus.MAC_WE = 1'b0; bus.SAT = 1'b0;

        tick(); tick();
        r_rst = 1'b0;
        bus.CBUS_REQ = 1'b1; #1;
        check("reset_busy", {63'd0, bus.CBUS_BUSY}, 64'd0);
        bus.CBUS_REQ = 1'b0;
        check_mac("reset_mac", 32'h0, 32'h0);

        cmd(c_lds, 2'b10, 32'h12345678, 1'b0);
        rd(1'b1, v);
        check("lds_mach_raw", {32'd0, v}, 64'h12345678);
        cmd(c_lds, 2'b01, 32'h11111111, 1'b0);
        check_mac("lds_both", 32'h12345678, 32'h11111111);

        // MULS.W: latency of N+1 enabled edges after issue
        cmd(c_mulsw, 2'b10, 32'hFFFE0003, 1'b0);
        repeat (4) tick();
        check_mac("mulsw_not_yet", 32'h12345678, 32'h11111111);
        tick();
        check_mac("mulsw", 32'h12345678, 32'hFFFFFFFA);

        cmd(c_muluw, 2'b10, 32'hFFFE0003, 1'b0);
        repeat (5) tick();
        check_mac("muluw", 32'h12345678, 32'h0002FFFA);

        // DMULU with an LDS attempt while busy that must be rejected
        cmd(c_dmulu, 2'b01, 32'hFFFFFFFF, 1'b0);
        cmd(c_dmulu, 2'b10, 32'hFFFFFFFF, 1'b0);
        tick();
        bus.MAC_OP = c_lds; bus.MAC_SEL = 2'b01; bus.CBUS_DI = 32'h55555555; bus.MAC_WE = 1'b1;
        #1;
        check("busy_on_cmd", {63'd0, bus.CBUS_BUSY}, 64'd1);
        tick();
        bus.MAC_WE = 1'b0; bus.MAC_SEL = 2'b00;
        repeat (3) tick();
        check_mac("dmulu_ff", 32'hFFFFFFFE, 32'h00000001);

        cmd(c_dmuls, 2'b01, 32'hFFFFFFFF, 1'b0);
        cmd(c_dmuls, 2'b10, 32'hFFFFFFFF, 1'b0);
        repeat (5) tick();
        check_mac("dmuls_ff", 32'h00000000, 32'h00000001);

        cmd(c_dmulu, 2'b01, 32'h01000000, 1'b0);
        cmd(c_dmulu, 2'b10, 32'h00000100, 1'b0);
        repeat (5) tick();
        check_mac("dmulu_shift", 32'h00000001, 32'h00000000);

        cmd(c_lds, 2'b10, 32'hDEADBEEF, 1'b0);
        cmd(c_mull, 2'b01, 32'hFFFFFFFD, 1'b0);
        cmd(c_mull, 2'b10, 32'h00000007, 1'b0);
        repeat (5) tick();
        check_mac("mull_neg", 32'hDEADBEEF, 32'hFFFFFFEB);

        lds(32'h00007FFF, 32'hFFFFFFFF);
        cmd(c_macl, 2'b01, 32'h1, 1'b1);
        cmd(c_macl, 2'b10, 32'h1, 1'b1);
        repeat (5) tick();
`ifdef MAC_ITER_SAT_EN
        check_mac("macl_sat", 32'h00007FFF, 32'hFFFFFFFF);
`else
        check_mac("macl_sat", 32'h00008000, 32'h00000000);
`endif

        lds(32'h00000000, 32'hFFFFFFFF);
        cmd(c_macl, 2'b01, 32'hFFFFFFFE, 1'b0);
        cmd(c_macl, 2'b10, 32'h00000003, 1'b0);
        repeat (5) tick();
        check_mac("macl_neg", 32'h00000000, 32'hFFFFFFF9);

        lds(32'hA5A5A5A5, 32'h7FFFFFFF);
        cmd(c_macw, 2'b01, 32'h00000002, 1'b1);
        cmd(c_macw, 2'b10, 32'hFFFF0003, 1'b1);
        repeat (5) tick();
`ifdef MAC_ITER_SAT_EN
        check_mac("macw_sat", 32'hA5A5A5A5, 32'h7FFFFFFF);
`else
        check_mac("macw_sat", 32'hA5A5A5A5, 32'h80000005);
`endif

        lds(32'h00000000, 32'h00000010);
        cmd(c_macw, 2'b01, 32'h1234FFFF, 1'b0);
        cmd(c_macw, 2'b10, 32'h00000005, 1'b0);
        repeat (5) tick();
        check_mac("macw_neg", 32'h00000000, 32'h0000000B);

        cmd(c_clr, 2'b01, 32'h0, 1'b0);
        check_mac("clrmac", 32'h0, 32'h0);

        // BUSY duration with CPU read held, without and with CE_R gaps
        cmd(c_dmuls, 2'b01, 32'hFFFFFFFD, 1'b0);
        cmd(c_dmuls, 2'b10, 32'h00000005, 1'b0);
        busy_count(99, 99, n);
        check("busy_len", 64'(n), 64'd5);
        check("busy_read_mach", {32'd0, bus.CBUS_DO}, 64'hFFFFFFFF);
        bus.CBUS_REQ = 1'b0; bus.MAC_SEL = 2'b00;
        check_mac("dmuls_neg", 32'hFFFFFFFF, 32'hFFFFFFF1);

        cmd(c_dmulu, 2'b01, 32'h00000003, 1'b0);
        cmd(c_dmulu, 2'b10, 32'h00000005, 1'b0);
        busy_count(1, 3, n);
        check("busy_len_gap", 64'(n), 64'd8);
        bus.CBUS_REQ = 1'b0; bus.MAC_SEL = 2'b00;
        check_mac("dmulu_gap", 32'h00000000, 32'h0000000F);

        // Reset during the second RUN iteration aborts the operation
        lds(32'h89ABCDEF, 32'h01234567);
        cmd(c_dmulu, 2'b01, 32'h00000007, 1'b0);
        cmd(c_dmulu, 2'b10, 32'h00000009, 1'b0);
        tick();
        r_rst = 1'b1;
        tick();
        r_rst = 1'b0;
        bus.CBUS_REQ = 1'b1; #1;
        check("rst_busy", {63'd0, bus.CBUS_BUSY}, 64'd0);
        bus.CBUS_REQ = 1'b0;
        check_mac("rst_mac", 32'h0, 32'h0);
        cmd(c_lds, 2'b01, 32'hCAFEBABE, 1'b0);
        repeat (6) tick();
        check_mac("rst_lds", 32'h0, 32'hCAFEBABE);

        $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mac_iter_unit.md
# mac_iter_unit

Parametrised multiply/accumulate unit for the SH CPU core. It sits on the CPU internal bus beside the register file and holds MACH/MACL. Products are computed by an iterative shift-add multiplier that retires RB operand bits per enabled cycle, and the unit stalls the pipeline through CBUS_BUSY. It adds SH-correct MACL-only writes for short multiplies and optional MAC saturation driven by the SR.S bit.

## Interface
- W, 32: operand and MACH/MACL width. Must be even and a multiple of RB.
- RB, 8: multiplier bits retired per enabled cycle. N = W/RB iterations.
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- CE_R  in  1  clock enable. All state advances only on CLK edges with CE_R=1.
- CBUS_DI  in  W  operand / LDS data.
- CBUS_DO  out  W  MACH when MAC_SEL[1]=1, else MACL. Combinational from registers.
- CBUS_REQ  in  1  CPU reads MACH/MACL this cycle.
- CBUS_BUSY  out  1  stall request.
- MAC_SEL  in  2  bit0 selects MACL / first operand; bit1 selects MACH / second operand and issue.
- MAC_OP  in  4  operation code, listed under Operation.
- MAC_WE  in  1  command strobe.
- SAT  in  1  SR.S bit, sampled at issue.

## Operation
- A command is accepted when MAC_WE=1, MAC_SEL≠0, CE_R=1 and the unit is not busy.
- Opcodes:
  - 0000 LDS: loads MACL and/or MACH per MAC_SEL.
  - 0001 MUL.L: result to MACL only; MACH unchanged.
  - 0010 DMULU.L and 0011 DMULS.L: full 2W result to MACH:MACL.
  - 0110 MULU.W and 0111 MULS.W: MA=DI[W/2-1:0], MB=DI[W-1:W/2], zero- or sign-extended per op bit0. Low W bits go to MACL; MACH unchanged.
  - 1001 MAC.L: signed product accumulated into MACH:MACL.
  - 1011 MAC.W: signed W/2 operands, low half of DI at each step.
  - 1111 CLRMAC: MACH=MACL=0.
  - Other codes: ignored.
- Operand loading: MAC_SEL[0] loads MA and MAC_SEL[1] loads MB. Any accepted command with MAC_SEL[1]=1 on a multiply/MAC op issues it and latches op, SIGNED and SAT.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on issue. The iteration counter is loaded with N−1; magnitudes |MA| and |MB| are latched when SIGNED, plus the sign of the product.
  - RUN: each enabled cycle adds (MB_mag × MA_mag[RB-1:0]) << (k·RB) into a 2W partial and shifts MA_mag right by RB. On counter = 0 → DONE.
  - DONE: applies the two's-complement negate if needed, then accumulates or saturates and writes the destination → IDLE.
- Saturation (only when compiled in, for MAC ops with latched SAT=1):
  - MAC.L clamps the sum to signed 3W/2 bits, sign-extended into MACH.
  - MAC.W clamps to signed W bits in MACL; MACH is unchanged.
  - With SAT=0, MAC ops wrap modulo 2^2W.
- CBUS_BUSY = (state≠IDLE) & (CBUS_REQ | (MAC_WE & MAC_SEL≠0)).
  - Commands and reads arriving while busy are not accepted. The CPU holds them until BUSY drops.
  - An independent instruction never stalls.

## Timing
- Reset (RST=1 at an edge): MACL, MACH, MA, MB and the partial product clear to 0; state goes to IDLE; CBUS_BUSY=0. CBUS_DO=0 from the next cycle. Reset mid-operation aborts the operation with no register write.
- Latency: if issue occurs at enabled edge 0, the destination is written at enabled edge N+1. The new value is visible on CBUS_DO in the cycle after that edge. With N=4 this is 5 enabled cycles.
- While CE_R=0: counter, state and partial product hold. BUSY is still evaluated combinationally.
- Back-to-back: a command presented in the cycle after DONE is accepted with no bubble. A command presented during DONE sees BUSY=1 and is accepted on the next enabled edge.
- LDS to MACL/MACH and CLRMAC take effect at the accepting edge; read-after-write costs zero cycles.

## Configuration
- MAC_ITER_SAT_EN defined: the saturation datapath and clamp compare are built, and SAT is honoured for MAC.L and MAC.W.
- Not defined: SAT is ignored and all MAC results wrap modulo 2^2W. No clamp logic is present.

## Test plan
- MULS.W with DI=0xFFFE0003, MACH preset to 0x12345678 → after 5 enabled cycles MACL=0xFFFFFFFA and MACH=0x12345678.
- DMULU.L 0xFFFFFFFF×0xFFFFFFFF → MACH=0xFFFFFFFE, MACL=0x00000001. Repeat as DMULS.L → MACH=0x00000000, MACL=0x00000001.
- MAC.L with SAT=1, MACH:MACL=0x00007FFF:FFFFFFFF, operands 1×1 → with the macro, unchanged at 0x00007FFF:FFFFFFFF. Without the macro → 0x00008000:00000000.
- MAC.W with SAT=1, MACL=0x7FFFFFFF, MACH=0xA5A5A5A5, operands 2 and 3 → MACL=0x7FFFFFFF and MACH=0xA5A5A5A5 (macro on).
- Issue DMULS.L, then hold CBUS_REQ=1 with MAC_SEL=2 → BUSY high for exactly 5 cycles, then CBUS_DO shows the correct MACH. Inserting CE_R=0 gaps stretches BUSY by the number of gap cycles.
- Assert RST during the second RUN iteration → next cycle MACH=MACL=0 and BUSY=0. A following LDS MACL of 0xCAFEBABE is read back correctly.
